// File: rtl/biotensor_pkg.sv
// Shared Q16.16 constants and the cosine-stage state encoding.
// FRAC_BITS is shared with the arccos stage that consumes x_out.
package biotensor_pkg;

    localparam int          FRAC_BITS   = 16;
    localparam logic [31:0] ONE_Q16     = 32'h0001_0000;
    localparam logic [31:0] NEG_ONE_Q16 = 32'hFFFF_0000;

    // Q2.16 quotient magnitude: two integer bits cover the floor-rounding overshoot of 1.0
    localparam int DIV_BITS = FRAC_BITS + 2;

    typedef enum logic [2:0] {
        ST_ACCUM = 3'd0,
        ST_MUL   = 3'd1,
        ST_SQRT  = 3'd2,
        ST_DIV   = 3'd3,
        ST_OUT   = 3'd4
    } cos_state_e;

endpackage

// File: rtl/isqrt_serial.sv
// Restoring integer square root, one root bit per cycle, MSB first.
// The first bit is resolved on the start edge itself, so W/2 edges yield the full root.
module isqrt_serial #(
    parameter int W = 108
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     radicand,
    output logic [W/2-1:0]   root,
    output logic             done
);

    localparam int RW = W / 2;
    localparam int CW = $clog2(RW + 1);

    logic [W-1:0]    rad_q;
    logic [RW+1:0]   rem_q;
    logic [CW-1:0]   cnt_q;
    logic            run_q;

    logic [W-1:0]    rad_src;
    logic [RW+1:0]   rem_src;
    logic [RW-1:0]   root_src;
    logic [RW+3:0]   rem_t;
    logic [RW+3:0]   trial;
    logic [RW+3:0]   rem_n;
    logic [RW-1:0]   root_n;
    logic            ge;

    always_comb begin
        rad_src  = start ? radicand : rad_q;
        rem_src  = start ? '0 : rem_q;
        root_src = start ? '0 : root;
        // Bring down the next two radicand bits and try subtracting 4*root+1
        rem_t    = {rem_src, rad_src[W-1 -: 2]};
        trial    = {2'b00, root_src, 2'b01};
        ge       = (rem_t >= trial);
        rem_n    = ge ? (rem_t - trial) : rem_t;
        root_n   = RW'({root_src, ge});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q <= '0;
            rem_q <= '0;
            root  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || run_q) begin
                rad_q <= rad_src << 2;
                rem_q <= (RW+2)'(rem_n);
                root  <= root_n;
            end
            if (start) begin
                cnt_q <= CW'(RW - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cos_sim_norm.sv
// Streams two integer vectors and produces cos(theta) = a.b / (|a||b|) in Q16.16,
// clamped to [-1, +1], with a fixed latency from the last accepted beat.
module cos_sim_norm
    import biotensor_pkg::*;
#(
    parameter int ELEM_W  = 16,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [ELEM_W-1:0] a_in,
    input  logic [ELEM_W-1:0] b_in,
    output logic [31:0]       x_out,
    output logic              valid_out,
    output logic              busy,
    output logic              zero_norm,
    output logic              trunc,
    output logic [2:0]        state_dbg
);

    localparam int CNT_W  = $clog2(MAX_LEN);
    localparam int ACC_W  = 2 * ELEM_W + CNT_W;
    localparam int R_W    = ACC_W + FRAC_BITS;
    localparam int SQ_W   = 2 * R_W;
    localparam int DC_W   = $clog2(DIV_BITS);
    localparam int PRE_SH = 2 * FRAC_BITS - DIV_BITS;

    cos_state_e state_q, state_d;

    logic signed [ACC_W-1:0] dot_q;
    logic [ACC_W-1:0]        na_q, nb_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    trunc_pend_q;
    logic [R_W:0]            rem_q;
    logic [DIV_BITS-1:0]     quo_q;
    logic [DC_W-1:0]         dcnt_q;

    logic                    accept, at_max, sq_start, sq_done;
    logic [R_W-1:0]          sq_root;
    logic signed [2*ELEM_W-1:0] prod_ab;
    logic [2*ELEM_W-1:0]     prod_aa, prod_bb;
    logic [2*ACC_W-1:0]      p_full;
    logic [ACC_W-1:0]        dot_mag;
    logic [R_W+1:0]          drem_t, drem_n;
    logic                    dge;
    logic [31:0]             mag, x_next;

    // A beat transfers on any edge where in_valid && in_ready; in_valid with in_ready low is dropped.
    assign in_ready  = (state_q == ST_ACCUM) && !rst;
    assign accept    = in_valid && in_ready;
    assign at_max    = (cnt_q == CNT_W'(MAX_LEN - 1));
    assign busy      = (state_q != ST_ACCUM) || (cnt_q != '0);
    assign state_dbg = state_q;

    always_comb begin
        prod_ab = $signed(a_in) * $signed(b_in);
        prod_aa = $signed(a_in) * $signed(a_in);
        prod_bb = $signed(b_in) * $signed(b_in);
        p_full  = na_q * nb_q;
        dot_mag = dot_q[ACC_W-1] ? $unsigned(-dot_q) : $unsigned(dot_q);
        drem_t  = {rem_q, 1'b0};
        dge     = (drem_t >= {2'b00, sq_root});
        drem_n  = dge ? (drem_t - {2'b00, sq_root}) : drem_t;
        mag     = (quo_q > DIV_BITS'(ONE_Q16)) ? ONE_Q16 : 32'(quo_q);
        if (sq_root == '0) mag = '0;
        if (dot_q[ACC_W-1]) x_next = (mag == ONE_Q16) ? NEG_ONE_Q16 : -mag;
        else                x_next = mag;
    end

    isqrt_serial #(.W(SQ_W)) u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sq_start),
        .radicand ({p_full, {(2*FRAC_BITS){1'b0}}}),
        .root     (sq_root),
        .done     (sq_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        sq_start = 1'b0;
        case (state_q)
            ST_ACCUM: if (accept && (in_last || at_max)) state_d = ST_MUL;
            ST_MUL: begin
                sq_start = 1'b1;
                state_d  = ST_SQRT;
            end
            ST_SQRT:  if (sq_done) state_d = ST_DIV;
            ST_DIV:   if (dcnt_q == DC_W'(DIV_BITS - 1)) state_d = ST_OUT;
            ST_OUT:   state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dot_q        <= '0;
            na_q         <= '0;
            nb_q         <= '0;
            cnt_q        <= '0;
            trunc_pend_q <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            dcnt_q       <= '0;
            x_out        <= '0;
            valid_out    <= 1'b0;
            zero_norm    <= 1'b0;
            trunc        <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                ST_ACCUM: if (accept) begin
                    dot_q        <= dot_q + ACC_W'(prod_ab);
                    na_q         <= na_q + ACC_W'(prod_aa);
                    nb_q         <= nb_q + ACC_W'(prod_bb);
                    cnt_q        <= cnt_q + CNT_W'(1);
                    trunc_pend_q <= at_max && !in_last;
                end
                // Dividend |dot|*2^32 has 32 zero LSBs; preloading |dot|<<14 leaves 18 quotient steps
                ST_SQRT: if (sq_done) begin
                    rem_q  <= (R_W+1)'({dot_mag, {PRE_SH{1'b0}}});
                    quo_q  <= '0;
                    dcnt_q <= '0;
                end
                ST_DIV: begin
                    rem_q  <= (R_W+1)'(drem_n);
                    quo_q  <= DIV_BITS'({quo_q, dge});
                    dcnt_q <= dcnt_q + DC_W'(1);
                end
                ST_OUT: begin
                    x_out        <= x_next;
                    valid_out    <= 1'b1;
                    zero_norm    <= (sq_root == '0);
                    trunc        <= trunc_pend_q;
                    dot_q        <= '0;
                    na_q         <= '0;
                    nb_q         <= '0;
                    cnt_q        <= '0;
                    trunc_pend_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_sim_norm.sv
// Directed bench for cos_sim_norm: an arithmetic reference model feeds a scoreboard
// that is checked on every valid_out, plus literal checks on the documented vectors.
module tb_cos_sim_norm;
    import biotensor_pkg::*;

    localparam int  LAT = 74;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [15:0] a_in, b_in;
    logic [31:0] x_out;
    logic        valid_out, busy, zero_norm, trunc;
    logic [2:0]  state_dbg;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          va[$];
    int          vb[$];
    logic [33:0] exp_q[$];
    time         acc_q[$];

    cos_sim_norm #(.ELEM_W(16), .MAX_LEN(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .a_in      (a_in),
        .b_in      (b_in),
        .x_out     (x_out),
        .valid_out (valid_out),
        .busy      (busy),
        .zero_norm (zero_norm),
        .trunc     (trunc),
        .state_dbg (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // reference model: exact integer arithmetic on the whole vector
    function automatic logic [33:0] model(input bit tr);
        longint       dot = 0;
        logic [127:0] na = '0, nb = '0, nn, r, c, num, m;
        logic [31:0]  x;
        bit           zn;
        for (int i = 0; i < va.size(); i++) begin
            dot += longint'(va[i]) * longint'(vb[i]);
            na  += 128'(longint'(va[i]) * longint'(va[i]));
            nb  += 128'(longint'(vb[i]) * longint'(vb[i]));
        end
        nn = (na * nb) << 32;
        r  = '0;
        for (int k = 63; k >= 0; k--) begin
            c = r | (128'd1 << k);
            if (c * c <= nn) r = c;
        end
        zn = (r == '0);
        if (zn) x = '0;
        else begin
            num = 128'((dot < 0) ? -dot : dot) << 32;
            m   = num / r;
            if (m > 128'd65536) m = 128'd65536;
            x = (dot < 0) ? 32'(-m) : 32'(m);
        end
        return {tr, zn, x};
    endfunction

    // driver tasks
    task automatic clr();
        va.delete();
        vb.delete();
    endtask

    task automatic add(input int a, input int b);
        va.push_back(a);
        vb.push_back(b);
    endtask

    task automatic send_vec(input bit use_last, input bit expect_res);
        int  n = va.size();
        int  k;
        time t_acc = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            a_in     = 16'(va[i]);
            b_in     = 16'(vb[i]);
            in_last  = use_last && (i == n - 1);
            k = 0;
            while (!in_ready && k < 400) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (expect_res) begin
            exp_q.push_back(model(!use_last));
            acc_q.push_back(t_acc);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) check("result_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // scoreboard compare process
    initial begin
        logic [33:0] e;
        time         t;
        forever begin
            @(negedge clk);
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'(valid_out), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_q.pop_front();
                    check("x_out", 64'(x_out), 64'(e[31:0]));
                    check("zero_norm", 64'(zero_norm), 64'(e[32]));
                    check("trunc", 64'(trunc), 64'(e[33]));
                    check("latency", 64'((($time - 5) - t) / 10), 64'(LAT));
                    check("ready_at_valid", 64'(in_ready), 64'd1);
                    check("busy_at_valid", 64'(busy), 64'd0);
                end
            end
        end
    end

    // stimulus
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_x_out", 64'(x_out), 64'd0);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_zero_norm", 64'(zero_norm), 64'd0);
        check("rst_trunc", 64'(trunc), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_state", 64'(state_dbg), 64'(ST_ACCUM));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'd1);
        @(negedge clk);

        // model pinned to hand-computed values
        clr(); add(1, 1); add(0, 1);
        check("model_b505", 64'(model(1'b0)), 64'h0_0000_B505);
        clr(); add(3, -3); add(4, -4);
        check("model_neg_one", 64'(model(1'b0)), 64'h0_FFFF_0000);
        clr(); add(0, 5); add(0, 7);
        check("model_zero_norm", 64'(model(1'b0)), 64'h1_0000_0000);

        // a=b=[1,2,3], then in_valid held high while the block is busy
        clr(); add(1, 1); add(2, 2); add(3, 3);
        send_vec(1'b1, 1'b1);
        check("busy_mid", 64'(busy), 64'd1);
        in_valid = 1'b1; in_last = 1'b1; a_in = 16'h7FFF; b_in = 16'h8000;
        repeat (20) @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        wait_idle();
        check("lit_parallel", 64'(x_out), 64'h0001_0000);

        // two vectors back to back: the second starts in the valid_out cycle
        clr(); add(1, 0); add(0, 1);
        send_vec(1'b1, 1'b1);
        clr(); add(3, -3); add(4, -4);
        send_vec(1'b1, 1'b1);
        wait_idle();
        check("lit_antiparallel", 64'(x_out), 64'hFFFF_0000);

        clr(); add(1, 1); add(0, 1);
        send_vec(1'b1, 1'b1);
        wait_idle();
        check("lit_b505", 64'(x_out), 64'h0000_B505);

        clr(); add(0, 5); add(0, 7);
        send_vec(1'b1, 1'b1);
        wait_idle();
        check("lit_zero_norm_flag", 64'(zero_norm), 64'd1);
        check("lit_zero_norm_x", 64'(x_out), 64'd0);

        clr(); add(5, -1); add(-3, 4); add(2, 7);
        send_vec(1'b1, 1'b1);
        wait_idle();
        clr(); add(-7, 3);
        send_vec(1'b1, 1'b1);
        wait_idle();
        check("lit_len1_neg", 64'(x_out), 64'hFFFF_0000);

        // 64 extreme beats with no in_last
        clr();
        for (int i = 0; i < 64; i++) add(32767, -32768);
        send_vec(1'b0, 1'b1);
        wait_idle();
        check("lit_trunc_flag", 64'(trunc), 64'd1);
        check("lit_trunc_x", 64'(x_out), 64'hFFFF_0000);

        // reset while the square root is running
        clr(); add(1, 1); add(2, 2);
        send_vec(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_x_out", 64'(x_out), 64'd0);
        check("abort_trunc", 64'(trunc), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_no_valid", 64'(valid_out), 64'd0);
        clr(); add(2, 2);
        send_vec(1'b1, 1'b1);
        wait_idle();
        check("lit_after_abort", 64'(x_out), 64'h0001_0000);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
